// File: rtl/multdiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_issue
// Purpose  : Issue/handshake stage between execute and the multicycle
//            multiply/divide units. Accepts a mult or div request, latches
//            operands and destination, pulses the unit start control, holds
//            the operands and stalls the pipeline until the unit reports
//            ready (or a timeout expires), then presents the result or an
//            exception plus $rstatus code to writeback for one cycle.
// Ports    : clock, reset (sync, active-high)
//            start_mult/start_div, operand_a/b, rd_in     <- execute
//            md_result, md_exception, md_resultRDY         <- mult/div unit
//            ctrl_MULT/ctrl_DIV, md_operandA/B             -> mult/div unit
//            stall                                         -> pipeline
//            wb_valid, wb_rd, wb_data, wb_exception,
//            wb_status                                     -> writeback
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_issue #(
    parameter int TIMEOUT     = 48,
    parameter int MULT_STATUS = 4,
    parameter int DIV_STATUS  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    output logic [31:0] wb_status
);

    localparam int          c_cnt_w        = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [31:0] c_mult_status  = 32'(MULT_STATUS);
    localparam logic [31:0] c_div_status   = 32'(DIV_STATUS);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_issue = 2'd1;
    localparam logic [1:0]  c_st_wait  = 2'd2;
    localparam logic [1:0]  c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_op;          // 1 = div, 0 = mult
    logic [31:0]        r_opa;
    logic [31:0]        r_opb;
    logic [4:0]         r_rd;
    logic [c_cnt_w-1:0] r_cnt;
    logic [4:0]         r_wb_rd;
    logic [31:0]        r_wb_data;
    logic               r_wb_exc;
    logic [31:0]        r_wb_status;

    logic               w_accept;
    logic               w_capture_rdy;
    logic               w_capture_tmo;
    logic [31:0]        w_exc_status;

    // A request in IDLE is accepted the same cycle it is seen.
    assign w_accept      = (r_state == c_st_idle) && (start_mult || start_div);
    // Unit ready outranks the timeout when both happen in the same WAIT cycle.
    assign w_capture_rdy = (r_state == c_st_wait) && md_resultRDY;
    assign w_capture_tmo = (r_state == c_st_wait) && !md_resultRDY && (r_cnt == c_cnt_last);
    assign w_exc_status  = r_op ? c_div_status : c_mult_status;

    // Next-state and control outputs
    always_comb begin
        w_next_state = r_state;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        case (r_state)
            c_st_idle: begin
                stall = w_accept;
                if (w_accept) begin
                    w_next_state = c_st_issue;
                end
            end
            c_st_issue: begin
                ctrl_DIV     = r_op;
                ctrl_MULT    = !r_op;
                stall        = 1'b1;
                w_next_state = c_st_wait;
            end
            c_st_wait: begin
                stall = 1'b1;
                if (w_capture_rdy || w_capture_tmo) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: begin
                wb_valid     = 1'b1;
                w_next_state = c_st_idle;
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // State register and datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_op        <= 1'b0;
            r_opa       <= 32'd0;
            r_opb       <= 32'd0;
            r_rd        <= 5'd0;
            r_cnt       <= '0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_wb_exc    <= 1'b0;
            r_wb_status <= 32'd0;
        end else begin
            r_state <= w_next_state;

            if (w_accept) begin
                // Divide wins when both requests arrive together.
                r_op  <= start_div;
                r_opa <= operand_a;
                r_opb <= operand_b;
                r_rd  <= rd_in;
            end

            if (r_state == c_st_issue) begin
                r_cnt <= '0;
            end else if (r_state == c_st_wait) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_capture_rdy) begin
                r_wb_rd     <= r_rd;
                r_wb_data   <= md_result;
                r_wb_exc    <= md_exception;
                r_wb_status <= md_exception ? w_exc_status : 32'd0;
            end else if (w_capture_tmo) begin
                r_wb_rd     <= r_rd;
                r_wb_data   <= 32'd0;
                r_wb_exc    <= 1'b1;
                r_wb_status <= w_exc_status;
            end
        end
    end

    assign md_operandA  = r_opa;
    assign md_operandB  = r_opb;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign wb_exception = r_wb_exc;
    assign wb_status    = r_wb_status;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_issue
// Purpose  : Self-checking bench for multdiv_issue. Directed vector table,
//            reset-during-operation sequence and randomized operations
//            checked against a cycle-count/arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue;

    localparam int TIMEOUT     = 48;
    localparam int MULT_STATUS = 4;
    localparam int DIV_STATUS  = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] md_operandA, md_operandB;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic [31:0] wb_status;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    multdiv_issue #(
        .TIMEOUT     (TIMEOUT),
        .MULT_STATUS (MULT_STATUS),
        .DIV_STATUS  (DIV_STATUS)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .start_mult   (start_mult),
        .start_div    (start_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .rd_in        (rd_in),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception),
        .wb_status    (wb_status)
    );

    // One operation: request at cycle 0, unit ready rdy cycles after the
    // ctrl pulse (rdy < 0: never), plus the expected writeback.
    typedef struct {
        bit          div;
        bit          mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          rdy;
        logic [31:0] res;
        bit          exc;
        logic [31:0] exp_data;
        bit          exp_exc;
        logic [31:0] exp_status;
        int          exp_cycle;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " ctrl_MULT"},    32'(ctrl_MULT), 32'd0);
        chk({tag, " ctrl_DIV"},     32'(ctrl_DIV), 32'd0);
        chk({tag, " md_operandA"},  md_operandA, 32'd0);
        chk({tag, " md_operandB"},  md_operandB, 32'd0);
        chk({tag, " stall"},        32'(stall), 32'd0);
        chk({tag, " wb_valid"},     32'(wb_valid), 32'd0);
        chk({tag, " wb_rd"},        32'(wb_rd), 32'd0);
        chk({tag, " wb_data"},      wb_data, 32'd0);
        chk({tag, " wb_exception"}, 32'(wb_exception), 32'd0);
        chk({tag, " wb_status"},    wb_status, 32'd0);
    endtask

    task automatic drive_idle();
        start_mult   = 1'b0;
        start_div    = 1'b0;
        operand_a    = $urandom;
        operand_b    = $urandom;
        rd_in        = 5'($urandom);
        md_result    = $urandom;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;
    endtask

    // Reference model: writeback timing and content from the stated rules.
    // Ready seen at cycle k counts only while waiting (cycles 2..TIMEOUT+1);
    // otherwise the forced timeout lands writeback at cycle TIMEOUT+2.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   k = (v.rdy < 0) ? -1 : v.rdy + 1;
        bit   is_div = v.div;
        if (k >= 2 && k <= TIMEOUT + 1) begin
            r.exp_cycle  = k + 1;
            r.exp_data   = v.res;
            r.exp_exc    = v.exc;
            r.exp_status = v.exc ? (is_div ? DIV_STATUS : MULT_STATUS) : 0;
        end else begin
            r.exp_cycle  = TIMEOUT + 2;
            r.exp_data   = 32'd0;
            r.exp_exc    = 1'b1;
            r.exp_status = is_div ? DIV_STATUS : MULT_STATUS;
        end
        return r;
    endfunction

    // Called #1 after a rising edge with the DUT idle. Inputs other than the
    // cycle-0 request are noise: starts, operands and a stale ready during
    // the ctrl cycle must all be ignored.
    task automatic run_op(input vec_t v, input string tag);
        int k = (v.rdy < 0) ? -1 : v.rdy + 1;
        for (int c = 0; c <= v.exp_cycle; c++) begin
            if (c == 0) begin
                start_div  = v.div;
                start_mult = v.mult;
                operand_a  = v.a;
                operand_b  = v.b;
                rd_in      = v.rd;
            end else begin
                start_div  = 1'($urandom);
                start_mult = 1'($urandom);
                operand_a  = $urandom;
                operand_b  = $urandom;
                rd_in      = 5'($urandom);
            end
            if (c == k) begin
                md_resultRDY = 1'b1;
                md_result    = v.res;
                md_exception = v.exc;
            end else begin
                md_resultRDY = (c == 1) || (c == v.exp_cycle && 1'($urandom));
                md_result    = $urandom;
                md_exception = 1'($urandom);
            end
            @(negedge clock);
            chk({tag, " stall"},     32'(stall), 32'(c < v.exp_cycle));
            chk({tag, " ctrl_DIV"},  32'(ctrl_DIV), 32'(c == 1 && v.div));
            chk({tag, " ctrl_MULT"}, 32'(ctrl_MULT), 32'(c == 1 && !v.div));
            chk({tag, " wb_valid"},  32'(wb_valid), 32'(c == v.exp_cycle));
            if (c >= 1) begin
                chk({tag, " md_operandA"}, md_operandA, v.a);
                chk({tag, " md_operandB"}, md_operandB, v.b);
            end
            if (c == v.exp_cycle) begin
                chk({tag, " wb_rd"},        32'(wb_rd), 32'(v.rd));
                chk({tag, " wb_data"},      wb_data, v.exp_data);
                chk({tag, " wb_exception"}, 32'(wb_exception), 32'(v.exp_exc));
                chk({tag, " wb_status"},    wb_status, v.exp_status);
            end
            @(posedge clock);
            #1;
        end
        // Idle cycle afterwards: writeback fields hold, strobe is low.
        drive_idle();
        @(negedge clock);
        chk({tag, " post wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, " post stall"},    32'(stall), 32'd0);
        chk({tag, " post wb_data"},  wb_data, v.exp_data);
        chk({tag, " post wb_rd"},    32'(wb_rd), 32'(v.rd));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        //           div mult a             b             rd  rdy res           exc  exp_data      exc status cyc
        vecs[0] = '{1'b1, 1'b0, 32'd100,      32'hFFFFFFF9, 5'd3,  5,  32'hFFFFFFF2, 1'b0, 32'hFFFFFFF2, 1'b0, 32'd0, 7};
        vecs[1] = '{1'b1, 1'b0, 32'd55,       32'd0,        5'd7,  3,  32'd0,        1'b1, 32'd0,        1'b1, 32'd5, 5};
        vecs[2] = '{1'b0, 1'b1, 32'h7FFFFFFF, 32'd2,        5'd9,  2,  32'hFFFFFFFE, 1'b1, 32'hFFFFFFFE, 1'b1, 32'd4, 4};
        vecs[3] = '{1'b1, 1'b1, 32'd1234,     32'd56,       5'd12, 1,  32'd22,       1'b0, 32'd22,       1'b0, 32'd0, 3};
        vecs[4] = '{1'b0, 1'b1, 32'd3,        32'd4,        5'd31, -1, 32'd0,        1'b0, 32'd0,        1'b1, 32'd4, 50};
        vecs[5] = '{1'b1, 1'b0, 32'd9,        32'd3,        5'd1,  -1, 32'd0,        1'b0, 32'd0,        1'b1, 32'd5, 50};
        vecs[6] = '{1'b0, 1'b1, 32'd11,       32'd13,       5'd20, 48, 32'd143,      1'b0, 32'd143,      1'b0, 32'd0, 50};
        vecs[7] = '{1'b0, 1'b1, 32'd6,        32'd7,        5'd17, 10, 32'd42,       1'b0, 32'd42,       1'b0, 32'd0, 12};

        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check_reset_outputs("in reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("after reset");
        @(posedge clock);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while waiting on the unit.
        start_div = 1'b1;
        operand_a = 32'hDEADBEEF;
        operand_b = 32'h12345678;
        rd_in     = 5'd5;
        @(posedge clock);
        #1;
        drive_idle();
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst-mid pre stall", 32'(stall), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_reset_outputs("rst-mid");
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst-mid idle ctrl_DIV", 32'(ctrl_DIV), 32'd0);
        chk("rst-mid idle stall",    32'(stall), 32'd0);
        @(posedge clock);
        #1;
        run_op(vecs[7], "after-rst");

        // Randomized operations against the reference model.
        for (int i = 0; i < 20; i++) begin
            rv.div  = 1'($urandom);
            rv.mult = rv.div ? 1'($urandom) : 1'b1;
            rv.a    = $urandom;
            rv.b    = $urandom;
            rv.rd   = 5'($urandom);
            rv.rdy  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 50));
            rv.res  = $urandom;
            rv.exc  = 1'($urandom);
            rv = model(rv);
            run_op(rv, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multdiv_issue.md
# multdiv_issue

Issue/handshake stage between the processor's execute stage and the multicycle multiply/divide units. It accepts a mult or div request from execute and latches the operands and destination register. It then pulses the unit's start control and holds the operands stable for the whole operation, stalling the pipeline until the unit reports ready. It captures the result, or an exception plus $rstatus code, and presents it to writeback for exactly one cycle.

## Interface
- TIMEOUT, 48: max cycles spent in WAIT before a forced timeout exception; counter width is clog2(TIMEOUT+1).
- MULT_STATUS, 4: $rstatus value reported for a mult exception.
- DIV_STATUS, 5: $rstatus value reported for a div exception.

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high
- start_mult  in  1  execute requests multiply this cycle
- start_div  in  1  execute requests divide this cycle
- operand_a  in  32  rs value from execute
- operand_b  in  32  rt value from execute
- rd_in  in  5  destination register
- md_result  in  32  unit result
- md_exception  in  1  unit exception flag, valid with md_resultRDY
- md_resultRDY  in  1  unit result-ready strobe
- ctrl_MULT  out  1  one-cycle start pulse to multiplier
- ctrl_DIV  out  1  one-cycle start pulse to divider
- md_operandA  out  32  latched operand A, held until DONE
- md_operandB  out  32  latched operand B, held until DONE
- stall  out  1  freeze fetch/decode/execute
- wb_valid  out  1  writeback strobe, one cycle
- wb_rd  out  5  destination register for writeback
- wb_data  out  32  result to write
- wb_exception  out  1  write wb_status to $rstatus (r30)
- wb_status  out  32  $rstatus code, 0 when no exception

## Operation
- States: IDLE, ISSUE, WAIT, DONE (2-bit register).
- IDLE:
  - If start_div or start_mult is high, latch operand_a, operand_b, rd_in and op (div=1, mult=0), then go to ISSUE.
  - If both are high, div wins and mult is dropped.
- ISSUE:
  - Assert ctrl_DIV or ctrl_MULT (per latched op) for this single cycle.
  - Clear the timeout counter, then go to WAIT.
  - md_resultRDY is ignored in this state.
- WAIT:
  - Counter increments each cycle.
  - If md_resultRDY is high: capture wb_data=md_result, wb_exception=md_exception, wb_status = md_exception ? (op ? DIV_STATUS : MULT_STATUS) : 0; go to DONE.
  - Else, if the counter equals TIMEOUT-1: capture wb_data=0, wb_exception=1, wb_status per op; go to DONE.
  - md_resultRDY takes priority over timeout in the same cycle.
- DONE: wb_valid=1; go to IDLE.
- start_mult/start_div are ignored in ISSUE, WAIT and DONE. Execute is stalled in those states, so it re-presents the same request only after release.
- md_operandA/B always drive the latched registers and change only on an IDLE acceptance.
- ctrl_MULT/ctrl_DIV are never high outside ISSUE and never both high.

## Timing
- Reset values: state=IDLE; ctrl_MULT=ctrl_DIV=0; md_operandA/B=0; stall=0; wb_valid=0; wb_rd=0; wb_data=0; wb_exception=0; wb_status=0; counter=0.
- stall = (IDLE & (start_mult|start_div)) | ISSUE | WAIT. stall is combinational in the request cycle and is 0 in DONE.
- With acceptance at cycle 0 and md_resultRDY first seen at cycle k (k≥2):
  - ctrl pulse at cycle 1.
  - wb_valid at cycle k+1.
  - stall high for cycles 0..k.
- Reset mid-operation returns to IDLE next edge with all outputs at reset values and no ctrl pulse. The downstream unit's leftover state is harmless: the next ISSUE pulse restarts it.
- wb_* registers hold their values after DONE until the next capture. Only wb_valid qualifies them.

## Test plan
- Div, stub ready 5 cycles after ctrl: start_div, A=100, B=-7, rd=3 at cycle 0, stub returns -14 -> ctrl_DIV at cycle 1 only; stall high cycles 0–6; wb_valid cycle 7 with wb_rd=3, wb_data=0xFFFFFFF2, wb_exception=0, wb_status=0.
- Div by zero: stub returns 0 with md_exception=1 -> wb_exception=1, wb_status=5, wb_data=0.
- Mult overflow: start_mult, stub asserts md_exception -> ctrl_MULT only; wb_status=4.
- Both starts together plus stale md_resultRDY during ISSUE -> only ctrl_DIV pulses; stale ready ignored; md_operandA/B unchanged while operand_a/b toggle during WAIT.
- Stub never ready -> wb_valid exactly TIMEOUT+2 cycles after acceptance (cycle 50 for default 48), wb_data=0, wb_exception=1, wb_status per op.
- Reset asserted during WAIT -> next cycle all outputs at reset values. A subsequent start completes normally.
